// File: rtl/dsp_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per enabled clock,
// with clock enable, abort and a divide-by-zero shortcut.
module dsp_divider #(
  parameter int DIVIDEND_W = 36,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DIVZ,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DIVIDEND_W-1:0] dvd, dvd_nxt, q_nxt;
  logic [DIVISOR_W-1:0]  rem, rem_nxt, dvs, dvs_nxt, r_nxt;
  logic                  divz_nxt;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W-1:0]  diff;
  logic                  fits;
  logic [DIVIDEND_W-1:0] dvd_step;
  logic [DIVISOR_W-1:0]  rem_step;

  // The quotient bits shift into the bottom of dvd as the dividend bits leave the top.
  assign shifted  = {rem, dvd[DIVIDEND_W-1]};
  assign fits     = (shifted >= {1'b0, dvs});
  assign diff     = shifted[DIVISOR_W-1:0] - dvs;
  assign rem_step = fits ? diff : shifted[DIVISOR_W-1:0];
  assign dvd_step = {dvd[DIVIDEND_W-2:0], fits};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dvd_nxt   = dvd;
    rem_nxt   = rem;
    dvs_nxt   = dvs;
    q_nxt     = Q;
    r_nxt     = R;
    divz_nxt  = DIVZ;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START && !ABORT) begin
          dvd_nxt   = DIVIDEND;
          dvs_nxt   = DIVISOR;
          rem_nxt   = '0;
          cnt_nxt   = CNT_W'(DIVIDEND_W);
          state_nxt = ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else if (dvs == '0) begin
          q_nxt     = '1;
          r_nxt     = '0;
          divz_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          dvd_nxt = dvd_step;
          rem_nxt = rem_step;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            q_nxt     = dvd_step;
            r_nxt     = rem_step;
            divz_nxt  = 1'b0;
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CE gates every register, so a stall freezes DONE as well as the iteration.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      rem   <= '0;
      dvs   <= '0;
      Q     <= '0;
      R     <= '0;
      DIVZ  <= 1'b0;
    end else if (CE) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dvd   <= dvd_nxt;
      rem   <= rem_nxt;
      dvs   <= dvs_nxt;
      Q     <= q_nxt;
      R     <= r_nxt;
      DIVZ  <= divz_nxt;
    end
  end

  assign BUSY = (state == ST_BUSY);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_dsp_divider.sv
// Directed bench for dsp_divider: latency, results, zero divisor, stall, abort
// and asynchronous reset, each against hand-computed values.
module tb_dsp_divider;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        start;
  logic        abort;
  logic [35:0] dividend;
  logic [17:0] divisor;
  logic        busy;
  logic        done;
  logic        divz;
  logic [35:0] q;
  logic [17:0] r;

  int checks   = 0;
  int failures = 0;
  int edges;
  int busy_cycles;
  int done_seen;

  dsp_divider #(.DIVIDEND_W(36), .DIVISOR_W(18)) dut (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .START(start), .ABORT(abort),
    .DIVIDEND(dividend), .DIVISOR(divisor),
    .BUSY(busy), .DONE(done), .DIVZ(divz), .Q(q), .R(r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after a falling edge; the next rising edge accepts START.
  task automatic start_op(input logic [35:0] a, input logic [17:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until DONE, with a hard bound.
  task automatic wait_done(input int first, output int n, output int nbusy);
    n     = first;
    nbusy = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_divz", divz, 0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    start_op(36'd100, 18'd7);
    check("basic_busy_after_accept", busy, 1);
    wait_done(0, edges, busy_cycles);
    check("basic_latency", edges, 36);
    check("basic_busy_cycles", busy_cycles, 36);
    check("basic_done", done, 1);
    check("basic_q", q, 14);
    check("basic_r", r, 2);
    check("basic_divz", divz, 0);
    @(negedge clk);
    check("basic_done_one_cycle", done, 0);
    check("basic_q_hold", q, 14);

    // Full-scale operands, second one started back-to-back in the DONE cycle
    start_op(36'hFFFFFFFFF, 18'h3FFFF);
    wait_done(0, edges, busy_cycles);
    check("fs1_latency", edges, 36);
    check("fs1_q", q, 36'h000040001);
    check("fs1_r", r, 0);
    start_op(36'hFFFFFFFFF, 18'd1);
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(0, edges, busy_cycles);
    check("fs2_latency", edges, 36);
    check("fs2_q", q, 36'hFFFFFFFFF);
    check("fs2_r", r, 0);
    @(negedge clk);

    // Divide by zero, then DONE held through a CE stall
    start_op(36'd55, 18'd0);
    wait_done(0, edges, busy_cycles);
    check("divz_latency", edges, 1);
    check("divz_q", q, 36'hFFFFFFFFF);
    check("divz_r", r, 0);
    check("divz_flag", divz, 1);
    ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("divz_done_frozen", done, 1);
    ce = 1'b1;
    @(negedge clk);
    check("divz_done_released", done, 0);
    check("divz_flag_hold", divz, 1);

    start_op(36'd9, 18'd4);
    wait_done(0, edges, busy_cycles);
    check("after_divz_latency", edges, 36);
    check("after_divz_q", q, 2);
    check("after_divz_r", r, 1);
    check("after_divz_flag", divz, 0);
    @(negedge clk);

    // CE stall of 5 cycles mid-BUSY plus an ignored START
    start_op(36'd100, 18'd7);
    edges = 0;
    repeat (10) begin @(negedge clk); edges++; end
    ce = 1'b0;
    repeat (5) begin @(negedge clk); edges++; end
    check("stall_busy_held", busy, 1);
    ce       = 1'b1;
    dividend = 36'd50;
    divisor  = 18'd3;
    start    = 1'b1;
    @(negedge clk);
    edges++;
    start = 1'b0;
    wait_done(edges, edges, busy_cycles);
    check("stall_latency", edges, 41);
    check("stall_q", q, 14);
    check("stall_r", r, 2);
    @(negedge clk);

    // Abort at the tenth BUSY cycle, with START on the same edge
    start_op(36'd100, 18'd9);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    done_seen = 0;
    repeat (50) begin @(negedge clk); if (done || busy) done_seen++; end
    check("abort_no_done", done_seen, 0);
    check("abort_q_kept", q, 14);
    check("abort_r_kept", r, 2);
    check("abort_divz_kept", divz, 0);

    // Asynchronous reset between clock edges mid-operation
    start_op(36'd100, 18'd7);
    repeat (19) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_divz", divz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (50) begin @(negedge clk); if (done || busy) done_seen++; end
    check("rst_no_done", done_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
